block_stats_calc: RTL

- Producer side of the Wiener statistics interface. Accepts a raster-ordered pixel stream grouped into blocks of TOTAL_SAMPLES pixels.
- Computes each block's mean and variance and stores the block's pixels in a ping-pong buffer.
- Replays the stored pixels with a stats_ready strobe, in exactly the form wiener_calc consumes: stats plus first pixel in the same cycle, then one pixel per cycle.
- Tracks the block count within a frame.

---
 rtl/block_stats_calc.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/block_stats_calc.sv
// block_stats_calc: collects TOTAL_SAMPLES-pixel blocks, computes mean and
// variance, stores each block in a ping-pong buffer and replays it with the
// stats presented alongside the first replayed pixel.
module block_stats_calc #(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SAMPLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    input  logic [31:0]               blocks_per_frame,
    output logic                      stats_ready,
    output logic [2*DATA_WIDTH-1:0]   mean_of_block,
    output logic [2*DATA_WIDTH-1:0]   variance_of_block,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_out_valid,
    output logic [31:0]               block_index,
    output logic                      frame_done
);

    localparam int LOG2N  = $clog2(TOTAL_SAMPLES);
    localparam int SUM_W  = DATA_WIDTH + LOG2N;
    localparam int SQ_W   = 2*DATA_WIDTH + LOG2N;
    localparam int PROD_W = 2*SUM_W;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(TOTAL_SAMPLES-1);

    typedef enum logic {W_FILL, W_CALC} wr_state_t;
    typedef enum logic {R_IDLE, R_PLAY} rd_state_t;

    // Ping-pong storage and per-buffer results
    logic [DATA_WIDTH-1:0]   mem      [2][TOTAL_SAMPLES];
    logic [1:0]              buf_full;
    logic [2*DATA_WIDTH-1:0] buf_mean [2];
    logic [2*DATA_WIDTH-1:0] buf_var  [2];
    logic [31:0]             buf_bpf  [2];

    // Write side
    wr_state_t               wr_state, wr_state_next;
    logic                    calc_step;
    logic                    wr_sel;
    logic [LOG2N-1:0]        wr_cnt;
    logic [SUM_W-1:0]        sum;
    logic [SQ_W-1:0]         sumsq;
    logic [PROD_W-1:0]       nsumsq;
    logic [PROD_W-1:0]       sum_sq;
    logic [31:0]             wr_blk;
    logic [31:0]             wr_bpf;
    logic [31:0]             eff_bpf;
    logic                    accept;
    logic                    calc_done;
    logic [DATA_WIDTH-1:0]   calc_mean;
    logic [2*DATA_WIDTH-1:0] calc_var;

    // Read side
    rd_state_t               rd_state, rd_state_next;
    logic                    rd_sel;
    logic [LOG2N-1:0]        rd_cnt;
    logic [31:0]             rd_blk;
    logic                    rd_start;
    logic                    rd_start_sel;
    logic                    rd_last;

    // Write FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= W_FILL;
        else     wr_state <= wr_state_next;
    end

    // Write FSM next state, handshake and stats arithmetic
    always_comb begin
        wr_state_next = wr_state;
        data_in_ready = (wr_state == W_FILL) && !buf_full[wr_sel];
        accept        = data_in_valid && data_in_ready;
        calc_done     = (wr_state == W_CALC) && calc_step;
        eff_bpf       = (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
        calc_mean     = DATA_WIDTH'(sum >> LOG2N);
        calc_var      = (2*DATA_WIDTH)'((nsumsq - sum_sq) >> (2*LOG2N));
        case (wr_state)
            W_FILL: if (accept && wr_cnt == LAST_IDX) wr_state_next = W_CALC;
            W_CALC: if (calc_step) wr_state_next = W_FILL;
            default: wr_state_next = W_FILL;
        endcase
    end

    // Write datapath: accumulation, two-step stats pipeline, buffer hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_step   <= 1'b0;
            wr_sel      <= 1'b0;
            wr_cnt      <= '0;
            sum         <= '0;
            sumsq       <= '0;
            nsumsq      <= '0;
            sum_sq      <= '0;
            wr_blk      <= '0;
            wr_bpf      <= 32'd1;
            buf_mean[0] <= '0;
            buf_mean[1] <= '0;
            buf_var[0]  <= '0;
            buf_var[1]  <= '0;
            buf_bpf[0]  <= 32'd1;
            buf_bpf[1]  <= 32'd1;
        end else if (wr_state == W_FILL) begin
            calc_step <= 1'b0;
            if (accept) begin
                sum    <= sum + SUM_W'(data_in);
                sumsq  <= sumsq + SQ_W'(data_in) * SQ_W'(data_in);
                wr_cnt <= wr_cnt + LOG2N'(1);
                if (wr_cnt == '0 && wr_blk == '0) wr_bpf <= eff_bpf;
            end
        end else if (!calc_step) begin
            nsumsq    <= {sumsq, {LOG2N{1'b0}}};
            sum_sq    <= PROD_W'(sum) * PROD_W'(sum);
            calc_step <= 1'b1;
        end else begin
            buf_mean[wr_sel] <= {{DATA_WIDTH{1'b0}}, calc_mean};
            buf_var[wr_sel]  <= calc_var;
            buf_bpf[wr_sel]  <= wr_bpf;
            wr_sel           <= ~wr_sel;
            sum              <= '0;
            sumsq            <= '0;
            calc_step        <= 1'b0;
            wr_blk           <= (wr_blk == wr_bpf - 32'd1) ? 32'd0 : wr_blk + 32'd1;
        end
    end

    // Pixel storage (contents are qualified by buf_full, so no reset needed)
    always_ff @(posedge clk) begin
        if (accept) mem[wr_sel][wr_cnt] <= data_in;
    end

    // Buffer occupancy: set by the writer, cleared by the reader; the two
    // never target the same buffer in one cycle since the writer only fills
    // an empty buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= '0;
        end else begin
            if (calc_done) buf_full[wr_sel] <= 1'b1;
            if (rd_last)   buf_full[rd_sel] <= 1'b0;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_state_next;
    end

    // Read FSM next state: start on a full buffer, chain replays back-to-back
    always_comb begin
        rd_state_next = rd_state;
        rd_start      = 1'b0;
        rd_start_sel  = rd_sel;
        rd_last       = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (buf_full[rd_sel]) begin
                    rd_start      = 1'b1;
                    rd_state_next = R_PLAY;
                end
            end
            R_PLAY: begin
                if (rd_cnt == LAST_IDX) begin
                    rd_last = 1'b1;
                    if (buf_full[~rd_sel]) begin
                        rd_start     = 1'b1;
                        rd_start_sel = ~rd_sel;
                    end else begin
                        rd_state_next = R_IDLE;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read datapath: replay counter, stats hold registers, block counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel            <= 1'b0;
            rd_cnt            <= '0;
            rd_blk            <= '0;
            mean_of_block     <= '0;
            variance_of_block <= '0;
        end else begin
            if (rd_start) begin
                rd_cnt            <= '0;
                mean_of_block     <= buf_mean[rd_start_sel];
                variance_of_block <= buf_var[rd_start_sel];
            end else if (rd_state == R_PLAY) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
            end
            if (rd_last) begin
                rd_sel <= ~rd_sel;
                rd_blk <= frame_done ? 32'd0 : rd_blk + 32'd1;
            end
        end
    end

    // Replay outputs decoded from read-side state
    always_comb begin
        data_out_valid = (rd_state == R_PLAY);
        stats_ready    = data_out_valid && (rd_cnt == '0);
        data_out       = data_out_valid ? mem[rd_sel][rd_cnt] : '0;
        frame_done     = rd_last && (rd_blk == buf_bpf[rd_sel] - 32'd1);
        block_index    = rd_blk;
    end

endmodule
